// File: rtl/iterative_half_add_ctrl.sv
// ----------------------------------------------------------------------------
// iterative_half_add_ctrl
//
// Multi-cycle N-bit adder. The sum is formed by repeated half-add steps on a
// partial-sum register x and a pending-carry register y. The loop stops as
// soon as no carries remain. Operands enter through a valid/ready handshake
// and the result leaves through another one. Only one operation is in flight
// at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request valid
//   in_ready   block is idle and can accept operands
//   a, b, ci   N-bit operands and carry in, sampled at acceptance only
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   c, co      sum (a+b+ci) mod 2^N and carry out, held between results
//   iters      number of carry-propagation steps for the presented result
//              (present only when ITERATIVE_HALF_ADD_CTRL_ITER_CNT_EN is
//              defined)
// ----------------------------------------------------------------------------
module iterative_half_add_ctrl #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         co
`ifdef ITERATIVE_HALF_ADD_CTRL_ITER_CNT_EN
    ,
    output logic [$clog2(N+1)-1:0] iters
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] x_q, x_d;
    logic [N-1:0] y_q, y_d;
    logic         acc_q, acc_d;   // carry out gathered while iterating
    logic [N-1:0] c_q, c_d;
    logic         co_q, co_d;
    logic         accept;

    // Step 0, taken directly from the operands.
    logic [N-1:0] load_x, load_y;
    logic         load_co;
    // One half-add step on the registered state.
    logic [N-1:0] step_x, step_y;
    logic         step_co;

    assign load_x  = a ^ b;
    assign load_y  = ((a & b) << 1) | {{(N-1){1'b0}}, ci};
    assign load_co = a[N-1] & b[N-1];

    assign step_x  = x_q ^ y_q;
    assign step_y  = (x_q & y_q) << 1;
    assign step_co = x_q[N-1] & y_q[N-1];

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        c_d     = c_q;
        co_d    = co_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    accept = 1'b1;
                    x_d    = load_x;
                    y_d    = load_y;
                    acc_d  = load_co;
                    if (load_y == '0) begin
                        state_d = StDone;
                        c_d     = load_x;
                        co_d    = load_co;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                x_d   = step_x;
                y_d   = step_y;
                acc_d = acc_q | step_co;
                if (step_y == '0) begin
                    state_d = StDone;
                    c_d     = step_x;
                    co_d    = acc_q | step_co;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= 1'b0;
            c_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            co_q    <= co_d;
        end
    end

    // Gated by rst_n so in_ready reads 0 while reset is held.
    assign in_ready  = (state_q == StIdle) && rst_n;
    assign out_valid = (state_q == StDone);
    assign c         = c_q;
    assign co        = co_q;

`ifdef ITERATIVE_HALF_ADD_CTRL_ITER_CNT_EN
    localparam int unsigned CntW = $clog2(N+1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == StRun) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign iters = cnt_q;
`endif

endmodule

// File: doc/iterative_half_add_ctrl.md
ITERATIVE_HALF_ADD_CTRL -- requirements
Module: iterative_half_add_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 32: operand and result width in bits, N >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have ports a and b, input, N bits each: operands A and B.
REQ-007 The block SHALL have port ci, input, 1 bit: carry in.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-010 The block SHALL have port c, output, N bits: sum, (a+b+ci) mod 2^N.
REQ-011 The block SHALL have port co, output, 1 bit: carry out, bit N of a+b+ci.

Function
REQ-012 The block SHALL compute the sum by repeated N-bit half-add steps on internal registers x (partial sum) and y (pending carries): x' = x^y, y' = (x&y)<<1.
REQ-013 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in RUN and DONE it SHALL be 0.
REQ-015 Acceptance SHALL occur on an edge with in_valid=1 and in_ready=1; a, b and ci SHALL be sampled only at that edge.
REQ-016 At acceptance, step 0 SHALL load x=a^b and y=((a&b)<<1)|ci, and set co to bit N-1 of a&b.
REQ-017 After acceptance, the FSM SHALL go to DONE if the loaded y is 0, otherwise to RUN.
REQ-018 Each RUN cycle SHALL apply one step (REQ-012) and OR bit N-1 of x&y into co.
REQ-019 RUN SHALL transition to DONE on the edge where the new y equals 0.
REQ-020 Latency SHALL be 1+k cycles from the acceptance edge to out_valid=1, where k is the number of RUN steps, 0 <= k <= N.
REQ-021 In DONE, out_valid SHALL be 1, and c=x and co SHALL be held stable until out_ready=1.
REQ-022 On an edge in DONE with out_ready=1, the FSM SHALL go to IDLE; accept and deliver SHALL never occur in the same cycle.
REQ-023 out_valid SHALL be 0 in IDLE and RUN, and c and co SHALL hold their last values there.
REQ-024 in_valid asserted in RUN or DONE SHALL be ignored, with no side effect.
REQ-025 out_ready asserted outside DONE SHALL be ignored.

Reset
REQ-026 On rst_n=0 the block SHALL asynchronously enter IDLE, with x, y, c and co = 0, out_valid=0 and in_ready=1 (in_ready=1 only while rst_n=1).
REQ-027 Reset asserted in RUN or DONE SHALL discard the operation in progress; no out_valid SHALL follow for it.
REQ-028 Reset deassertion SHALL be synchronised to clk by the integrator; the first accept is possible on the first edge after deassertion.

Configuration
REQ-029 With macro ITERATIVE_HALF_ADD_CTRL_ITER_CNT_EN defined, the block SHALL add output port iters, width $clog2(N+1), equal to k for the result presented.
REQ-030 With the macro defined, iters SHALL be reset to 0, cleared at acceptance, incremented per RUN step, and held with c.
REQ-031 Without the macro, port iters and its counter SHALL be absent, with otherwise identical behaviour and timing.

Verification (N=8)
REQ-032 The bench SHALL drive a=0x00, b=0x00, ci=0 -> c=0x00, co=0, out_valid 1 cycle after accept, iters=0.
REQ-033 The bench SHALL drive a=0x0F, b=0x01, ci=0 -> c=0x10, co=0, k=4, out_valid 5 cycles after accept.
REQ-034 The bench SHALL drive a=0xFF, b=0x00, ci=1 -> c=0x00, co=1, k=8, out_valid 9 cycles after accept (worst case).
REQ-035 The bench SHALL drive a=0x80, b=0x80, ci=0 with out_ready=0 for 3 cycles in DONE -> c=0x00, co=1 stable, in_ready=0, new in_valid ignored; IDLE the edge after out_ready=1.
REQ-036 The bench SHALL drive a=0xFF, b=0x01, assert rst_n=0 in the 3rd RUN cycle -> immediate IDLE, c=0, co=0, no out_valid; a following 0x01+0x02 -> c=0x03.
REQ-037 The bench SHALL run 10k random a, b, ci with random in_valid/out_ready -> every result equals {co,c} = a+b+ci, and latency equals 1+k.
